// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_CH byte-stream sources.
// Each grant emits a channel header byte followed by that channel's payload bytes.
module uart_tx_arbiter #(
    parameter int         NUM_CH      = 4,
    parameter int         MAX_LEN     = 32,
    parameter logic [7:0] HEADER_BASE = 8'hA0
) (
    input  logic                  sample_clock,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [NUM_CH*8-1:0]   req_data,
    input  logic [NUM_CH-1:0]     req_last,
    output logic [NUM_CH-1:0]     req_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [3:0]            grant_id,
    output logic                  busy,
    output logic                  trunc
);

    // state | meaning
    // IDLE  | no packet in flight; arbitrate among valid requesters
    // HDR   | presenting the header byte of the granted channel
    // PAY   | passing the granted channel's payload bytes straight to the UART
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    localparam logic [3:0] RR_INIT  = 4'(NUM_CH - 1);
    localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);

    state_t       state_q, state_d;
    logic [3:0]   grant_q, grant_d;
    logic [3:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]   len_cnt_q, len_cnt_d;
    logic         trunc_q, trunc_d;
    logic         busy_q, busy_d;

    // Fixed-width views so a 4-bit channel index selects cleanly for any NUM_CH.
    logic [15:0]  valid_ext;
    logic [15:0]  last_ext;
    logic [15:0]  ready_ext;
    logic [127:0] data_ext;

    logic         pick_found;
    logic [3:0]   pick_id;
    logic [3:0]   scan_idx;

    logic         pay_valid;
    logic         pay_last;
    logic [7:0]   pay_data;

    assign valid_ext = 16'(req_valid);
    assign last_ext  = 16'(req_last);
    assign data_ext  = 128'(req_data);

    assign pay_valid = valid_ext[grant_q];
    assign pay_last  = last_ext[grant_q];
    assign pay_data  = data_ext[{grant_q, 3'b000} +: 8];

    // First valid channel after the last one served, wrapping modulo NUM_CH.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            scan_idx = 4'((int'(rr_ptr_q) + k) % NUM_CH);
            if (!pick_found && valid_ext[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        len_cnt_d = len_cnt_q;
        trunc_d   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        ready_ext = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d   = pick_id;
                    len_cnt_d = '0;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER_BASE | {4'h0, grant_q};
                if (tx_ready) begin
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                tx_valid           = pay_valid;
                tx_data            = pay_data;
                ready_ext[grant_q] = tx_ready;
                if (pay_valid && tx_ready) begin
                    len_cnt_d = len_cnt_q + 8'd1;
                    // A final byte that also hits the length limit is a normal end, not a truncation.
                    if (pay_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_q;
                    end else if (len_cnt_q == LEN_LAST) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_q;
                        trunc_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sample_clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= RR_INIT;
            len_cnt_q <= '0;
            trunc_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            len_cnt_q <= len_cnt_d;
            trunc_q   <= trunc_d;
            busy_q    <= busy_d;
        end
    end

    assign req_ready = ready_ext[NUM_CH-1:0];
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign trunc     = trunc_q;

endmodule
